// File: rtl/frame_pkg.sv
// rtl/frame_pkg.sv - shared frame geometry, state encoding and width helper
package frame_pkg;

  localparam int DEFAULT_FRAME_WIDTH  = 240;
  localparam int DEFAULT_FRAME_HEIGHT = 320;
  localparam int DEFAULT_PIXEL_WIDTH  = 8;
  localparam int DEFAULT_ADDR_WIDTH   = 18;
  localparam int FRAME_PIXELS         = DEFAULT_FRAME_WIDTH * DEFAULT_FRAME_HEIGHT;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    HOLD  = 2'd2
  } fw_state_t;

  // Counter width for values 0..n-1, never narrower than one bit
  function automatic int count_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// rtl/raster_counter.sv - raster x/y position with running linear offset and last-pixel flag
module raster_counter
  import frame_pkg::*;
#(
  parameter int WIDTH        = DEFAULT_FRAME_WIDTH,
  parameter int HEIGHT       = DEFAULT_FRAME_HEIGHT,
  parameter int OFFSET_WIDTH = count_width(WIDTH * HEIGHT)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    inc,
  input  logic                    clear,
  output logic [OFFSET_WIDTH-1:0] offset,
  output logic                    last
);

  localparam int XW = count_width(WIDTH);
  localparam int YW = count_width(HEIGHT);

  logic [XW-1:0]           x, x_base, x_next;
  logic [YW-1:0]           y, y_base, y_next;
  logic [OFFSET_WIDTH-1:0] off_base, off_next;
  logic                    x_wrap, y_wrap;

  assign last = (x == XW'(WIDTH - 1)) && (y == YW'(HEIGHT - 1));

  // Clear applies first so clear+inc lands on the position after pixel 0
  always_comb begin
    x_base   = clear ? '0 : x;
    y_base   = clear ? '0 : y;
    off_base = clear ? '0 : offset;
    x_wrap   = (x_base == XW'(WIDTH - 1));
    y_wrap   = (y_base == YW'(HEIGHT - 1));
    x_next   = x_base;
    y_next   = y_base;
    off_next = off_base;
    if (inc) begin
      if (x_wrap) begin
        x_next = '0;
        y_next = y_wrap ? '0 : y_base + YW'(1);
      end else begin
        x_next = x_base + XW'(1);
      end
      off_next = (x_wrap && y_wrap) ? '0 : off_base + OFFSET_WIDTH'(1);
    end
  end

  // Position registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x      <= '0;
      y      <= '0;
      offset <= '0;
    end else begin
      x      <= x_next;
      y      <= y_next;
      offset <= off_next;
    end
  end

endmodule

// File: rtl/frame_writer.sv
// rtl/frame_writer.sv - double-buffered frame-buffer writer for a raster pixel stream
module frame_writer
  import frame_pkg::*;
#(
  parameter int FRAME_WIDTH  = DEFAULT_FRAME_WIDTH,
  parameter int FRAME_HEIGHT = DEFAULT_FRAME_HEIGHT,
  parameter int PIXEL_WIDTH  = DEFAULT_PIXEL_WIDTH,
  parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic [PIXEL_WIDTH-1:0] pixel_in,
  input  logic                   pixel_valid_in,
  input  logic                   pixel_sof_in,
  output logic                   pixel_ready_out,
  input  logic                   display_sof_in,
  output logic [ADDR_WIDTH-1:0]  wr_addr_out,
  output logic [PIXEL_WIDTH-1:0] wr_data_out,
  output logic                   wr_en_out,
  output logic                   display_buf_out,
  output logic                   frame_done_out,
  output logic                   frame_error_out
);

  localparam int FRAME_SIZE = FRAME_WIDTH * FRAME_HEIGHT;
  localparam int OFF_W      = count_width(FRAME_SIZE);
  localparam logic [ADDR_WIDTH-1:0] HI_BASE = ADDR_WIDTH'(FRAME_SIZE);

  fw_state_t        state, state_next;
  logic             wr_buf;
  logic             beat, sof_beat;
  logic             cnt_inc, cnt_clear;
  logic             wr_go, done_go, err_go, swap;
  logic [OFF_W-1:0] offset, wr_offset;
  logic             last;

  assign pixel_ready_out = (state != HOLD);
  assign beat            = pixel_valid_in && pixel_ready_out;
  assign sof_beat        = beat && pixel_sof_in;

  raster_counter #(
    .WIDTH        (FRAME_WIDTH),
    .HEIGHT       (FRAME_HEIGHT),
    .OFFSET_WIDTH (OFF_W)
  ) u_raster (
    .clk    (clk_in),
    .rst_n  (rst_n_in),
    .inc    (cnt_inc),
    .clear  (cnt_clear),
    .offset (offset),
    .last   (last)
  );

  // Next-state and per-beat write decisions
  always_comb begin
    state_next = state;
    cnt_inc    = 1'b0;
    cnt_clear  = 1'b0;
    wr_go      = 1'b0;
    done_go    = 1'b0;
    err_go     = 1'b0;
    swap       = 1'b0;
    wr_offset  = offset;
    case (state)
      IDLE: begin
        if (sof_beat) begin
          wr_go      = 1'b1;
          wr_offset  = '0;
          cnt_clear  = 1'b1;
          cnt_inc    = 1'b1;
          state_next = WRITE;
        end
      end
      WRITE: begin
        if (sof_beat) begin
          // A new frame start mid-frame restarts at pixel 0, even on the last pixel
          err_go    = 1'b1;
          wr_go     = 1'b1;
          wr_offset = '0;
          cnt_clear = 1'b1;
          cnt_inc   = 1'b1;
        end else if (beat) begin
          wr_go   = 1'b1;
          cnt_inc = 1'b1;
          if (last) begin
            done_go    = 1'b1;
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (display_sof_in) begin
          swap       = 1'b1;
          cnt_clear  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_next;
  end

  // Registered BRAM write port, status pulses and buffer ownership
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_en_out       <= 1'b0;
      wr_addr_out     <= '0;
      wr_data_out     <= '0;
      frame_done_out  <= 1'b0;
      frame_error_out <= 1'b0;
      wr_buf          <= 1'b0;
      display_buf_out <= 1'b1;
    end else begin
      wr_en_out       <= wr_go;
      frame_done_out  <= done_go;
      frame_error_out <= err_go;
      if (wr_go) begin
        wr_addr_out <= (wr_buf ? HI_BASE : '0) + ADDR_WIDTH'(wr_offset);
        wr_data_out <= pixel_in;
      end
      if (swap) begin
        display_buf_out <= wr_buf;
        wr_buf          <= ~wr_buf;
      end
    end
  end

endmodule

// File: tb/tb_frame_writer.sv
// tb/tb_frame_writer.sv - randomized self-checking bench for frame_writer
module tb_frame_writer;

  localparam int W  = 12;
  localparam int H  = 5;
  localparam int N  = W * H;
  localparam int PW = 8;
  localparam int AW = 7;

  localparam int M_IDLE  = 0;
  localparam int M_WRITE = 1;
  localparam int M_HOLD  = 2;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic [PW-1:0] pixel_in;
  logic          pixel_valid_in;
  logic          pixel_sof_in;
  logic          pixel_ready_out;
  logic          display_sof_in;
  logic [AW-1:0] wr_addr_out;
  logic [PW-1:0] wr_data_out;
  logic          wr_en_out;
  logic          display_buf_out;
  logic          frame_done_out;
  logic          frame_error_out;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: frame-level mode, linear pixel index, buffer ownership
  int m_mode;
  int m_p;
  int m_wbuf;
  int m_dbuf;

  frame_writer #(
    .FRAME_WIDTH  (W),
    .FRAME_HEIGHT (H),
    .PIXEL_WIDTH  (PW),
    .ADDR_WIDTH   (AW)
  ) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .pixel_in        (pixel_in),
    .pixel_valid_in  (pixel_valid_in),
    .pixel_sof_in    (pixel_sof_in),
    .pixel_ready_out (pixel_ready_out),
    .display_sof_in  (display_sof_in),
    .wr_addr_out     (wr_addr_out),
    .wr_data_out     (wr_data_out),
    .wr_en_out       (wr_en_out),
    .display_buf_out (display_buf_out),
    .frame_done_out  (frame_done_out),
    .frame_error_out (frame_error_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    m_p    = 0;
    m_wbuf = 0;
    m_dbuf = 1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wr_en"}, 32'(wr_en_out), 0);
    chk({tag, "_addr"},  32'(wr_addr_out), 0);
    chk({tag, "_data"},  32'(wr_data_out), 0);
    chk({tag, "_done"},  32'(frame_done_out), 0);
    chk({tag, "_err"},   32'(frame_error_out), 0);
    chk({tag, "_dbuf"},  32'(display_buf_out), 1);
    chk({tag, "_ready"}, 32'(pixel_ready_out), 1);
  endtask

  // One clock cycle of stimulus with full cycle-accurate comparison
  task automatic step(input logic v, input logic s, input logic [PW-1:0] d, input logic ds);
    logic e_en, e_done, e_err;
    int   e_addr, base;
    e_en = 1'b0; e_done = 1'b0; e_err = 1'b0; e_addr = 0;
    @(negedge clk_in);
    pixel_valid_in = v;
    pixel_sof_in   = s;
    pixel_in       = d;
    display_sof_in = ds;
    #1;
    chk("ready", 32'(pixel_ready_out), 32'(m_mode != M_HOLD));
    base = m_wbuf * N;
    if (v && m_mode != M_HOLD) begin
      if (s) begin
        e_en   = 1'b1;
        e_addr = base;
        e_err  = (m_mode == M_WRITE);
        m_p    = 1;
        m_mode = M_WRITE;
      end else if (m_mode == M_WRITE) begin
        e_en   = 1'b1;
        e_addr = base + m_p;
        m_p++;
        if (m_p == N) begin
          e_done = 1'b1;
          m_p    = 0;
          m_mode = M_HOLD;
        end
      end
    end else if (m_mode == M_HOLD && ds) begin
      m_dbuf = m_wbuf;
      m_wbuf = 1 - m_wbuf;
      m_mode = M_IDLE;
    end
    @(posedge clk_in);
    #1;
    chk("wr_en", 32'(wr_en_out), 32'(e_en));
    chk("frame_done", 32'(frame_done_out), 32'(e_done));
    chk("frame_error", 32'(frame_error_out), 32'(e_err));
    chk("display_buf", 32'(display_buf_out), 32'(m_dbuf));
    if (e_en) begin
      chk("wr_addr", 32'(wr_addr_out), 32'(e_addr));
      chk("wr_data", 32'(wr_data_out), 32'(d));
    end
  endtask

  // Random idle gap, then one valid pixel with random data
  task automatic push(input logic s, input logic ds);
    int gaps;
    gaps = $urandom_range(0, 2);
    repeat (gaps) step(1'b0, 1'b0, PW'($urandom), 1'b0);
    step(1'b1, s, PW'($urandom), ds);
  endtask

  task automatic full_frame();
    push(1'b1, 1'b0);
    repeat (N - 1) push(1'b0, 1'b0);
  endtask

  initial begin
    rst_n_in       = 1'b0;
    pixel_in       = '0;
    pixel_valid_in = 1'b0;
    pixel_sof_in   = 1'b0;
    display_sof_in = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    check_reset_outputs("reset");
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // Full frame into the low half, then stalled in HOLD
    full_frame();
    repeat (3) step(1'b1, 1'b0, PW'($urandom), 1'b0);

    // Swap, full frame into the high half, swap back
    step(1'b0, 1'b0, '0, 1'b1);
    full_frame();
    step(1'b0, 1'b0, '0, 1'b1);

    // Beats without sof while idle are dropped
    repeat (5) push(1'b0, 1'b0);

    // sof mid-frame restarts the frame
    push(1'b1, 1'b0);
    repeat (29) push(1'b0, 1'b0);
    push(1'b1, 1'b0);
    repeat (N - 1) push(1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);

    // sof on the last pixel restarts instead of completing
    push(1'b1, 1'b0);
    repeat (N - 2) push(1'b0, 1'b0);
    push(1'b1, 1'b0);
    repeat (N - 1) push(1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);

    // display sof coincident with the final beat is ignored
    push(1'b1, 1'b0);
    repeat (N - 2) push(1'b0, 1'b0);
    push(1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);

    // display sof outside HOLD has no effect
    step(1'b0, 1'b0, '0, 1'b1);

    // Reset mid-frame with valid held high
    push(1'b1, 1'b0);
    repeat (20) push(1'b0, 1'b0);
    @(negedge clk_in);
    pixel_valid_in = 1'b1;
    pixel_sof_in   = 1'b0;
    #2;
    rst_n_in = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    @(posedge clk_in);
    #1;
    check_reset_outputs("in_reset");
    @(negedge clk_in);
    rst_n_in       = 1'b1;
    pixel_valid_in = 1'b0;

    // After reset the next frame lands in the low half again
    full_frame();
    step(1'b0, 1'b0, '0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
